// File: rtl/mc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath enables and mux selects.
// Traps on an illegal opcode or a memory wait that exceeds MEM_TIMEOUT cycles.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic               ir_wr_en,
    output logic               pc_wr_en,
    output logic [1:0]         pc_src,
    output logic               reg_wr_en,
    output logic               reg_dst,
    output logic               wr_ra,
    output logic [1:0]         writeback_src,
    output logic               alu_src_b,
    output logic               ext_sel,
    output logic [2:0]         alu_command,
    output logic [2:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [COUNT_W-1:0] retire_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [5:0]         funct_q, funct_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [COUNT_W-1:0] retire_q, retire_d;
    logic [1:0]         cause_q, cause_d;

    logic is_r, is_add, is_sub, is_slt, is_jr;
    logic is_lw, is_sw, is_j, is_jal, is_bne, is_xori, is_legal;
    logic [2:0] op_cmd;
    logic       op_srcb, op_ext;

    logic       mem_rd_c, mem_wr_c, ir_wr_c, pc_wr_c, reg_wr_c, reg_dst_c, wr_ra_c;
    logic [1:0] pc_src_c, wb_src_c;
    logic [2:0] alu_cmd_c;
    logic       srcb_c, ext_c;
    logic       waiting;

    always_comb begin
        is_r     = (op_q == OP_RTYPE);
        is_add   = is_r && (funct_q == FN_ADD);
        is_sub   = is_r && (funct_q == FN_SUB);
        is_slt   = is_r && (funct_q == FN_SLT);
        is_jr    = is_r && (funct_q == FN_JR);
        is_lw    = (op_q == OP_LW);
        is_sw    = (op_q == OP_SW);
        is_j     = (op_q == OP_J);
        is_jal   = (op_q == OP_JAL);
        is_bne   = (op_q == OP_BNE);
        is_xori  = (op_q == OP_XORI);
        is_legal = is_add || is_sub || is_slt || is_jr || is_lw || is_sw ||
                   is_j || is_jal || is_bne || is_xori;
    end

    // ALU setup depends only on the latched op so it stays stable from DECODE to WB
    always_comb begin
        op_cmd  = ALU_ADD;
        op_srcb = 1'b0;
        op_ext  = 1'b0;
        if (is_sub || is_bne) begin
            op_cmd = ALU_SUB;
        end else if (is_slt) begin
            op_cmd = ALU_SLT;
        end else if (is_xori) begin
            op_cmd  = ALU_XOR;
            op_srcb = 1'b1;
        end else if (is_lw || is_sw) begin
            op_srcb = 1'b1;
            op_ext  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        cause_d   = cause_q;
        mem_rd_c  = 1'b0;
        mem_wr_c  = 1'b0;
        ir_wr_c   = 1'b0;
        pc_wr_c   = 1'b0;
        pc_src_c  = 2'd0;
        reg_wr_c  = 1'b0;
        reg_dst_c = 1'b0;
        wr_ra_c   = 1'b0;
        wb_src_c  = 2'd0;
        alu_cmd_c = 3'd0;
        srcb_c    = 1'b0;
        ext_c     = 1'b0;
        waiting   = 1'b0;

        if (state_q inside {DECODE, EXEC, MEM, WB}) begin
            alu_cmd_c = op_cmd;
            srcb_c    = op_srcb;
            ext_c     = op_ext;
        end

        case (state_q)
            FETCH: begin
                mem_rd_c = 1'b1;
                waiting  = !mem_ready;
                if (mem_ready) begin
                    ir_wr_c = 1'b1;
                    op_d    = opcode;
                    funct_d = funct;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!is_legal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_j) begin
                    pc_wr_c  = 1'b1;
                    pc_src_c = 2'd2;
                    state_d  = FETCH;
                end else if (is_jal) begin
                    state_d = WB;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = MEM;
                end else if (is_jr) begin
                    pc_wr_c  = 1'b1;
                    pc_src_c = 2'd1;
                    state_d  = FETCH;
                end else if (is_bne) begin
                    pc_wr_c  = 1'b1;
                    pc_src_c = alu_zero ? 2'd0 : 2'd3;
                    state_d  = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_rd_c = is_lw;
                mem_wr_c = !is_lw;
                waiting  = !mem_ready;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = WB;
                    end else begin
                        pc_wr_c = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                reg_wr_c = 1'b1;
                pc_wr_c  = 1'b1;
                state_d  = FETCH;
                if (is_lw) begin
                    wb_src_c  = 2'd1;
                    reg_dst_c = 1'b1;
                end else if (is_jal) begin
                    wb_src_c = 2'd2;
                    wr_ra_c  = 1'b1;
                    pc_src_c = 2'd2;
                end else if (is_xori) begin
                    reg_dst_c = 1'b1;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (waiting && (MEM_TIMEOUT > 0) && (wait_q == WAIT_LIMIT)) begin
            state_d = TRAP;
            cause_d = CAUSE_TIMEOUT;
        end

        if (waiting && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end

        retire_d = pc_wr_c ? retire_q + COUNT_W'(1) : retire_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            op_q     <= '0;
            funct_q  <= '0;
            wait_q   <= '0;
            retire_q <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            funct_q  <= funct_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            cause_q  <= cause_d;
        end
    end

    // Reset must silence the memory and write enables at once, not at the next edge
    assign mem_rd_en     = mem_rd_c && reset_n;
    assign mem_wr_en     = mem_wr_c && reset_n;
    assign ir_wr_en      = ir_wr_c && reset_n;
    assign pc_wr_en      = pc_wr_c && reset_n;
    assign reg_wr_en     = reg_wr_c && reset_n;
    assign wr_ra         = wr_ra_c && reset_n;
    assign pc_src        = pc_src_c;
    assign reg_dst       = reg_dst_c;
    assign writeback_src = wb_src_c;
    assign alu_src_b     = srcb_c;
    assign ext_sel       = ext_c;
    assign alu_command   = alu_cmd_c;
    assign state         = state_q;
    assign trap          = (state_q == TRAP);
    assign trap_cause    = cause_q;
    assign retire_count  = retire_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, hand-written reset sequence,
// then random instruction streams checked against a phase-list reference model.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       mem_rd_en;
        logic       mem_wr_en;
        logic       ir_wr_en;
        logic       pc_wr_en;
        logic [1:0] pc_src;
        logic       reg_wr_en;
        logic       reg_dst;
        logic       wr_ra;
        logic [1:0] writeback_src;
        logic       alu_src_b;
        logic       ext_sel;
        logic [2:0] alu_command;
        logic [2:0] state;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        string       name;
        logic        rn;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic        az;
        logic        mr;
        outs_t       exp;
        int unsigned ret;
    } vec_t;

    typedef struct {
        string      nm;
        logic [5:0] opc;
        logic [5:0] fn;
        logic [2:0] cmd;
        logic       sb;
        logic       ex;
        bit         exe;
        bit         mem;
        bit         wb;
    } op_t;

    typedef struct {
        logic  mr;
        logic  drv;
        outs_t exp;
    } cyc_t;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
    localparam int K_JR = 3, K_LW = 4, K_J = 6, K_JAL = 7, K_BNE = 8, K_XORI = 9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic        mem_rd_en, mem_wr_en, ir_wr_en, pc_wr_en, reg_wr_en, reg_dst, wr_ra;
    logic        alu_src_b, ext_sel, trap;
    logic [1:0]  pc_src, writeback_src, trap_cause;
    logic [2:0]  alu_command, state;
    logic [31:0] retire_count;
    outs_t       act;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    op_t  ops[10];
    cyc_t cyc[$];
    int unsigned ret_model;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(4), .COUNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .ir_wr_en(ir_wr_en),
        .pc_wr_en(pc_wr_en), .pc_src(pc_src), .reg_wr_en(reg_wr_en),
        .reg_dst(reg_dst), .wr_ra(wr_ra), .writeback_src(writeback_src),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_command(alu_command),
        .state(state), .trap(trap), .trap_cause(trap_cause),
        .retire_count(retire_count)
    );

    always_comb act = {mem_rd_en, mem_wr_en, ir_wr_en, pc_wr_en, pc_src, reg_wr_en, reg_dst,
                       wr_ra, writeback_src, alu_src_b, ext_sel, alu_command, state, trap,
                       trap_cause};

    function automatic outs_t so(input logic [2:0] s, input logic [2:0] cmd,
                                 input logic sb, input logic ex);
        outs_t r;
        r = '0;
        r.state = s;
        r.alu_command = cmd;
        r.alu_src_b = sb;
        r.ext_sel = ex;
        return r;
    endfunction

    function automatic outs_t fo(input logic ir);
        outs_t r;
        r = so(S_F, 3'd0, 1'b0, 1'b0);
        r.mem_rd_en = 1'b1;
        r.ir_wr_en = ir;
        return r;
    endfunction

    // Expected outputs for one cycle of instruction k in phase p, straight from the op rules
    function automatic outs_t ph(input int k, input logic [2:0] p, input logic mr, input logic az);
        outs_t r;
        r = '0;
        r.state = p;
        if (p != S_F) begin
            r.alu_command = ops[k].cmd;
            r.alu_src_b = ops[k].sb;
            r.ext_sel = ops[k].ex;
        end
        case (p)
            S_F: begin r.mem_rd_en = 1'b1; r.ir_wr_en = mr; end
            S_D: if (k == K_J) begin r.pc_wr_en = 1'b1; r.pc_src = 2'd2; end
            S_E: begin
                if (k == K_JR) begin r.pc_wr_en = 1'b1; r.pc_src = 2'd1; end
                if (k == K_BNE) begin r.pc_wr_en = 1'b1; r.pc_src = az ? 2'd0 : 2'd3; end
            end
            S_M: begin
                if (k == K_LW) r.mem_rd_en = 1'b1;
                else begin r.mem_wr_en = 1'b1; r.pc_wr_en = mr; end
            end
            S_W: begin
                r.reg_wr_en = 1'b1;
                r.pc_wr_en = 1'b1;
                if (k == K_LW) begin r.writeback_src = 2'd1; r.reg_dst = 1'b1; end
                if (k == K_XORI) r.reg_dst = 1'b1;
                if (k == K_JAL) begin r.writeback_src = 2'd2; r.wr_ra = 1'b1; r.pc_src = 2'd2; end
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic apply_stimulus(input logic rn, input logic [5:0] opc, input logic [5:0] fn,
                                  input logic az, input logic mr);
        @(negedge clk);
        reset_n = rn;
        opcode = opc;
        funct = fn;
        alu_zero = az;
        mem_ready = mr;
        #1;
    endtask

    task automatic check_output(input string name, input outs_t exp, input int unsigned ret);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s outputs: got %h expected %h (state got %0d expected %0d)",
                     name, act, exp, act.state, exp.state);
        end
        checks++;
        if (retire_count !== ret) begin
            failures++;
            $display("[TB] FAIL %s retire_count: got %0d expected %0d", name, retire_count, ret);
        end
    endtask

    task automatic push_vec(input string name, input logic rn, input logic [5:0] opc,
                            input logic [5:0] fn, input logic az, input logic mr,
                            input outs_t exp, input int unsigned ret);
        vec_t v;
        v.name = name; v.rn = rn; v.opc = opc; v.fn = fn; v.az = az; v.mr = mr;
        v.exp = exp; v.ret = ret;
        vecs.push_back(v);
    endtask

    task automatic fill_vectors();
        outs_t e;
        e = so(S_F, 0, 0, 0); push_vec("reset", 0, 6'h23, 6'h00, 0, 1, e, 0);
        // ADD with mem_ready tied high; opcode garbage after fetch proves latching
        push_vec("add_f", 1, 6'h00, 6'h20, 0, 1, fo(1), 0);
        e = so(S_D, 0, 0, 0); push_vec("add_d", 1, 6'h3F, 6'h3F, 0, 1, e, 0);
        e = so(S_E, 0, 0, 0); push_vec("add_e", 1, 6'h3F, 6'h3F, 0, 1, e, 0);
        e = so(S_W, 0, 0, 0); e.reg_wr_en = 1; e.pc_wr_en = 1;
        push_vec("add_w", 1, 6'h3F, 6'h3F, 0, 1, e, 0);
        // BNE not taken-zero then zero
        push_vec("bne0_f", 1, 6'h05, 6'h11, 0, 1, fo(1), 1);
        e = so(S_D, 1, 0, 0); push_vec("bne0_d", 1, 6'h3F, 6'h00, 0, 1, e, 1);
        e = so(S_E, 1, 0, 0); e.pc_wr_en = 1; e.pc_src = 3;
        push_vec("bne0_e", 1, 6'h3F, 6'h00, 0, 1, e, 1);
        push_vec("bne1_f", 1, 6'h05, 6'h2A, 1, 1, fo(1), 2);
        e = so(S_D, 1, 0, 0); push_vec("bne1_d", 1, 6'h00, 6'h00, 1, 1, e, 2);
        e = so(S_E, 1, 0, 0); e.pc_wr_en = 1; e.pc_src = 0;
        push_vec("bne1_e", 1, 6'h00, 6'h00, 1, 1, e, 2);
        // JAL then J
        push_vec("jal_f", 1, 6'h03, 6'h00, 0, 1, fo(1), 3);
        e = so(S_D, 0, 0, 0); push_vec("jal_d", 1, 6'h02, 6'h00, 0, 1, e, 3);
        e = so(S_W, 0, 0, 0); e.reg_wr_en = 1; e.pc_wr_en = 1; e.wr_ra = 1;
        e.writeback_src = 2; e.pc_src = 2; push_vec("jal_w", 1, 6'h02, 6'h00, 0, 1, e, 3);
        push_vec("j_f", 1, 6'h02, 6'h00, 0, 1, fo(1), 4);
        e = so(S_D, 0, 0, 0); e.pc_wr_en = 1; e.pc_src = 2;
        push_vec("j_d", 1, 6'h03, 6'h00, 0, 1, e, 4);
        // LW with two wait cycles in FETCH and two in MEM
        push_vec("lw_fw1", 1, 6'h23, 6'h00, 0, 0, fo(0), 5);
        push_vec("lw_fw2", 1, 6'h23, 6'h00, 0, 0, fo(0), 5);
        push_vec("lw_f", 1, 6'h23, 6'h00, 0, 1, fo(1), 5);
        e = so(S_D, 0, 1, 1); push_vec("lw_d", 1, 6'h00, 6'h00, 0, 0, e, 5);
        e = so(S_E, 0, 1, 1); push_vec("lw_e", 1, 6'h00, 6'h00, 0, 0, e, 5);
        e = so(S_M, 0, 1, 1); e.mem_rd_en = 1;
        push_vec("lw_mw1", 1, 6'h00, 6'h00, 0, 0, e, 5);
        push_vec("lw_mw2", 1, 6'h00, 6'h00, 0, 0, e, 5);
        push_vec("lw_m", 1, 6'h00, 6'h00, 0, 1, e, 5);
        e = so(S_W, 0, 1, 1); e.reg_wr_en = 1; e.pc_wr_en = 1; e.writeback_src = 1;
        e.reg_dst = 1; push_vec("lw_w", 1, 6'h00, 6'h00, 0, 0, e, 5);
        // XORI, SLT, JR
        push_vec("xori_f", 1, 6'h0E, 6'h08, 0, 1, fo(1), 6);
        e = so(S_D, 2, 1, 0); push_vec("xori_d", 1, 6'h00, 6'h00, 0, 1, e, 6);
        e = so(S_E, 2, 1, 0); push_vec("xori_e", 1, 6'h00, 6'h00, 0, 1, e, 6);
        e = so(S_W, 2, 1, 0); e.reg_wr_en = 1; e.pc_wr_en = 1; e.reg_dst = 1;
        push_vec("xori_w", 1, 6'h00, 6'h00, 0, 1, e, 6);
        push_vec("slt_f", 1, 6'h00, 6'h2A, 0, 1, fo(1), 7);
        e = so(S_D, 3, 0, 0); push_vec("slt_d", 1, 6'h00, 6'h20, 0, 1, e, 7);
        e = so(S_E, 3, 0, 0); push_vec("slt_e", 1, 6'h00, 6'h20, 0, 1, e, 7);
        e = so(S_W, 3, 0, 0); e.reg_wr_en = 1; e.pc_wr_en = 1;
        push_vec("slt_w", 1, 6'h00, 6'h20, 0, 1, e, 7);
        push_vec("jr_f", 1, 6'h00, 6'h08, 0, 1, fo(1), 8);
        e = so(S_D, 0, 0, 0); push_vec("jr_d", 1, 6'h00, 6'h20, 0, 1, e, 8);
        e = so(S_E, 0, 0, 0); e.pc_wr_en = 1; e.pc_src = 1;
        push_vec("jr_e", 1, 6'h00, 6'h20, 0, 1, e, 8);
        // SW stuck in MEM: fourth wait cycle traps, no pc_wr_en ever
        push_vec("sw_f", 1, 6'h2B, 6'h00, 0, 1, fo(1), 9);
        e = so(S_D, 0, 1, 1); push_vec("sw_d", 1, 6'h00, 6'h00, 0, 0, e, 9);
        e = so(S_E, 0, 1, 1); push_vec("sw_e", 1, 6'h00, 6'h00, 0, 0, e, 9);
        e = so(S_M, 0, 1, 1); e.mem_wr_en = 1;
        for (int i = 1; i <= 4; i++)
            push_vec($sformatf("sw_mw%0d", i), 1, 6'h00, 6'h00, 0, 0, e, 9);
        e = so(S_T, 0, 0, 0); e.trap = 1; e.trap_cause = 2;
        push_vec("sw_trap1", 1, 6'h00, 6'h00, 0, 1, e, 9);
        push_vec("sw_trap2", 1, 6'h23, 6'h00, 0, 1, e, 9);
        e = so(S_F, 0, 0, 0); push_vec("reset2", 0, 6'h00, 6'h00, 0, 1, e, 0);
        // Illegal opcode and illegal R-type funct
        push_vec("ill_f", 1, 6'h3F, 6'h00, 0, 1, fo(1), 0);
        e = so(S_D, 0, 0, 0); push_vec("ill_d", 1, 6'h00, 6'h20, 0, 1, e, 0);
        e = so(S_T, 0, 0, 0); e.trap = 1; e.trap_cause = 1;
        push_vec("ill_t1", 1, 6'h00, 6'h20, 0, 1, e, 0);
        push_vec("ill_t2", 1, 6'h02, 6'h00, 1, 0, e, 0);
        e = so(S_F, 0, 0, 0); push_vec("reset3", 0, 6'h00, 6'h01, 0, 1, e, 0);
        push_vec("illfn_f", 1, 6'h00, 6'h01, 0, 1, fo(1), 0);
        e = so(S_D, 0, 0, 0); push_vec("illfn_d", 1, 6'h00, 6'h20, 0, 1, e, 0);
        e = so(S_T, 0, 0, 0); e.trap = 1; e.trap_cause = 1;
        push_vec("illfn_t", 1, 6'h00, 6'h20, 0, 1, e, 0);
        e = so(S_F, 0, 0, 0); push_vec("reset4", 0, 6'h00, 6'h00, 0, 1, e, 0);
        // Reset mid-MEM aborts LW, then FETCH times out after four waits
        push_vec("lwr_f", 1, 6'h23, 6'h00, 0, 1, fo(1), 0);
        e = so(S_D, 0, 1, 1); push_vec("lwr_d", 1, 6'h00, 6'h00, 0, 1, e, 0);
        e = so(S_E, 0, 1, 1); push_vec("lwr_e", 1, 6'h00, 6'h00, 0, 1, e, 0);
        e = so(S_M, 0, 1, 1); e.mem_rd_en = 1; push_vec("lwr_m", 1, 6'h00, 6'h00, 0, 0, e, 0);
        e = so(S_F, 0, 0, 0); push_vec("lwr_rst", 0, 6'h00, 6'h00, 0, 0, e, 0);
        for (int i = 1; i <= 4; i++)
            push_vec($sformatf("fto_w%0d", i), 1, 6'h00, 6'h20, 0, 0, fo(0), 0);
        e = so(S_T, 0, 0, 0); e.trap = 1; e.trap_cause = 2;
        push_vec("fto_trap", 1, 6'h00, 6'h20, 0, 1, e, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        outs_t e;
        ops[0] = '{"ADD",  6'h00, 6'h20, 3'd0, 1'b0, 1'b0, 1, 0, 1};
        ops[1] = '{"SUB",  6'h00, 6'h22, 3'd1, 1'b0, 1'b0, 1, 0, 1};
        ops[2] = '{"SLT",  6'h00, 6'h2A, 3'd3, 1'b0, 1'b0, 1, 0, 1};
        ops[3] = '{"JR",   6'h00, 6'h08, 3'd0, 1'b0, 1'b0, 1, 0, 0};
        ops[4] = '{"LW",   6'h23, 6'h00, 3'd0, 1'b1, 1'b1, 1, 1, 1};
        ops[5] = '{"SW",   6'h2B, 6'h00, 3'd0, 1'b1, 1'b1, 1, 1, 0};
        ops[6] = '{"J",    6'h02, 6'h00, 3'd0, 1'b0, 1'b0, 0, 0, 0};
        ops[7] = '{"JAL",  6'h03, 6'h00, 3'd0, 1'b0, 1'b0, 0, 0, 1};
        ops[8] = '{"BNE",  6'h05, 6'h00, 3'd1, 1'b0, 1'b0, 1, 0, 0};
        ops[9] = '{"XORI", 6'h0E, 6'h00, 3'd2, 1'b1, 1'b0, 1, 0, 1};

        reset_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        fill_vectors();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rn, vecs[i].opc, vecs[i].fn, vecs[i].az, vecs[i].mr);
            check_output(vecs[i].name, vecs[i].exp, vecs[i].ret);
        end

        // Asynchronous reset between clock edges must drop mem_wr_en immediately
        apply_stimulus(0, 6'h00, 6'h00, 0, 1);
        apply_stimulus(1, 6'h2B, 6'h00, 0, 1);
        apply_stimulus(1, 6'h00, 6'h00, 0, 1);
        apply_stimulus(1, 6'h00, 6'h00, 0, 1);
        apply_stimulus(1, 6'h00, 6'h00, 0, 0);
        e = so(S_M, 0, 1, 1); e.mem_wr_en = 1;
        check_output("async_mem", e, 0);
        #2 reset_n = 1'b0;
        #1 check_output("async_drop", so(S_F, 0, 0, 0), 0);
        apply_stimulus(1, 6'h00, 6'h00, 0, 0);
        check_output("async_restart", fo(0), 0);

        // Random instruction stream against the phase-list model
        apply_stimulus(0, 6'h00, 6'h00, 0, 0);
        ret_model = 0;
        for (int n = 0; n < 150; n++) begin
            int k, wf, wm;
            logic az, r;
            logic [5:0] fn_i;
            k = $urandom_range(0, 9);
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            az = 1'($urandom_range(0, 1));
            fn_i = (ops[k].opc == 6'h00) ? ops[k].fn : 6'($urandom);
            cyc.delete();
            for (int w = 0; w < wf; w++) cyc.push_back('{1'b0, 1'b0, ph(k, S_F, 1'b0, az)});
            cyc.push_back('{1'b1, 1'b1, ph(k, S_F, 1'b1, az)});
            r = 1'($urandom_range(0, 1));
            cyc.push_back('{r, 1'b0, ph(k, S_D, r, az)});
            if (ops[k].exe) begin
                r = 1'($urandom_range(0, 1));
                cyc.push_back('{r, 1'b0, ph(k, S_E, r, az)});
            end
            if (ops[k].mem) begin
                for (int w = 0; w < wm; w++) cyc.push_back('{1'b0, 1'b0, ph(k, S_M, 1'b0, az)});
                cyc.push_back('{1'b1, 1'b0, ph(k, S_M, 1'b1, az)});
            end
            if (ops[k].wb) begin
                r = 1'($urandom_range(0, 1));
                cyc.push_back('{r, 1'b0, ph(k, S_W, r, az)});
            end
            foreach (cyc[i]) begin
                apply_stimulus(1, cyc[i].drv ? ops[k].opc : 6'($urandom),
                               cyc[i].drv ? fn_i : 6'($urandom), az, cyc[i].mr);
                check_output($sformatf("rand%0d_%s", n, ops[k].nm), cyc[i].exp, ret_model);
                if (cyc[i].exp.pc_wr_en) ret_model++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
